secure_debug_regfile: RTL and testbench

SECURE_DEBUG_REGFILE -- requirements
Module: secure_debug_regfile

---
 rtl/secure_dbg_pkg.sv | 17 +
 rtl/dbg_auth_fsm.sv | 93 +++++++++
 rtl/secure_debug_regfile.sv | 79 +++++++
 tb/tb_secure_debug_regfile.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/secure_dbg_pkg.sv
// Shared definitions for the secure debug register file: debug FSM states
// and the one-hot ALU opcodes.
package secure_dbg_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_CHECK    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } dbg_state_t;

  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b1000;

endpackage

// File: rtl/dbg_auth_fsm.sv
// Debug authentication FSM: key check, failed-attempt lockout and idle relock.
module dbg_auth_fsm
  import secure_dbg_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                MAX_FAILS    = 3,
  parameter int                IDLE_TIMEOUT = 255,
  parameter logic [DATA_W-1:0] DBG_KEY      = 32'hA5C3_0F96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbg_req,
  input  logic [DATA_W-1:0] dbg_key,
  input  logic              dbg_lock,
  input  logic              dbg_rd,
  output logic              unlocked,
  output logic              lockout
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(IDLE_TIMEOUT);

  dbg_state_t        state_q, state_nxt;
  logic [FW-1:0]     fail_q, fail_nxt;
  logic [TW-1:0]     idle_q, idle_nxt;
  logic [DATA_W-1:0] key_q, key_nxt;
  logic [TW-1:0]     idle_inc;

  assign idle_inc = idle_q + 1'b1;

  // State, fail counter, idle timer and captured key registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOCKED;
      fail_q  <= '0;
      idle_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_nxt;
      fail_q  <= fail_nxt;
      idle_q  <= idle_nxt;
      key_q   <= key_nxt;
    end
  end

  // Next-state logic; the idle timer only runs in UNLOCKED and relocks on
  // the edge where it would reach IDLE_TIMEOUT.
  always_comb begin
    state_nxt = state_q;
    fail_nxt  = fail_q;
    idle_nxt  = '0;
    key_nxt   = key_q;
    case (state_q)
      ST_LOCKED: begin
        if (dbg_req) begin
          key_nxt   = dbg_key;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        key_nxt = '0;
        if (key_q == DBG_KEY) begin
          state_nxt = ST_UNLOCKED;
          fail_nxt  = '0;
        end else begin
          fail_nxt  = fail_q + 1'b1;
          state_nxt = (fail_nxt == FAIL_LIMIT) ? ST_LOCKOUT : ST_LOCKED;
        end
      end
      ST_UNLOCKED: begin
        if (dbg_lock) begin
          state_nxt = ST_LOCKED;
        end else if (dbg_rd) begin
          idle_nxt = '0;
        end else if (idle_inc == IDLE_LIMIT) begin
          state_nxt = ST_LOCKED;
        end else begin
          idle_nxt = idle_inc;
        end
      end
      ST_LOCKOUT: begin
        state_nxt = ST_LOCKOUT;
      end
      default: state_nxt = ST_LOCKED;
    endcase
  end

  assign unlocked = (state_q == ST_UNLOCKED);
  assign lockout  = (state_q == ST_LOCKOUT);

endmodule

// File: rtl/secure_debug_regfile.sv
// Accumulator register file with one-hot ALU ops and a key-protected
// debug read port.
module secure_debug_regfile
  import secure_dbg_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                NUM_REGS     = 4,
  parameter int                MAX_FAILS    = 3,
  parameter int                IDLE_TIMEOUT = 255,
  parameter logic [DATA_W-1:0] DBG_KEY      = 32'hA5C3_0F96
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_W-1:0]           data_in,
  input  logic [$clog2(NUM_REGS)-1:0] reg_sel,
  input  logic [3:0]                  op,
  output logic [DATA_W-1:0]           data_out,
  input  logic                        dbg_req,
  input  logic [DATA_W-1:0]           dbg_key,
  input  logic                        dbg_lock,
  input  logic                        dbg_rd,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]           dbg_rdata,
  output logic                        dbg_rvalid,
  output logic                        dbg_unlocked,
  output logic                        dbg_lockout
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              rd_grant;

  dbg_auth_fsm #(
    .DATA_W       (DATA_W),
    .MAX_FAILS    (MAX_FAILS),
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .DBG_KEY      (DBG_KEY)
  ) u_auth (
    .clk      (clk),
    .rst      (rst),
    .dbg_req  (dbg_req),
    .dbg_key  (dbg_key),
    .dbg_lock (dbg_lock),
    .dbg_rd   (dbg_rd),
    .unlocked (dbg_unlocked),
    .lockout  (dbg_lockout)
  );

  // Register file update; anything other than a single opcode bit is a no-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (op)
        OP_LOAD: regs[reg_sel] <= data_in;
        OP_ADD:  regs[reg_sel] <= regs[reg_sel] + data_in;
        OP_SUB:  regs[reg_sel] <= regs[reg_sel] - data_in;
        OP_XOR:  regs[reg_sel] <= regs[reg_sel] ^ data_in;
        default: ;
      endcase
    end
  end

  assign data_out = regs[reg_sel];

  // A read is granted only while unlocked and not being relocked that cycle.
  assign rd_grant = dbg_unlocked && dbg_rd && !dbg_lock;

  // Registered debug read; sees the pre-update value of a same-cycle op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
    end else begin
      dbg_rvalid <= rd_grant;
      dbg_rdata  <= rd_grant ? regs[dbg_addr] : '0;
    end
  end

endmodule

// File: tb/tb_secure_debug_regfile.sv
// Randomized bench for secure_debug_regfile against a behavioural model.
module tb_secure_debug_regfile;

  localparam int          DW  = 32;
  localparam int          NR  = 4;
  localparam int          MF  = 3;
  localparam int          IT  = 255;
  localparam logic [31:0] KEY = 32'hA5C3_0F96;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic [1:0]  reg_sel = '0;
  logic [3:0]  op = '0;
  logic [31:0] data_out;
  logic        dbg_req = 1'b0;
  logic [31:0] dbg_key = '0;
  logic        dbg_lock = 1'b0;
  logic        dbg_rd = 1'b0;
  logic [1:0]  dbg_addr = '0;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;
  logic        dbg_unlocked;
  logic        dbg_lockout;

  secure_debug_regfile #(
    .DATA_W       (DW),
    .NUM_REGS     (NR),
    .MAX_FAILS    (MF),
    .IDLE_TIMEOUT (IT),
    .DBG_KEY      (KEY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .reg_sel      (reg_sel),
    .op           (op),
    .data_out     (data_out),
    .dbg_req      (dbg_req),
    .dbg_key      (dbg_key),
    .dbg_lock     (dbg_lock),
    .dbg_rd       (dbg_rd),
    .dbg_addr     (dbg_addr),
    .dbg_rdata    (dbg_rdata),
    .dbg_rvalid   (dbg_rvalid),
    .dbg_unlocked (dbg_unlocked),
    .dbg_lockout  (dbg_lockout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: access flags plus plain integer counters.
  logic [31:0] m_regs [NR];
  bit          m_unlocked, m_lockout, m_pending, m_key_ok;
  int          m_fails, m_idle;
  bit          m_rvalid;
  logic [31:0] m_rdata;

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_unlocked = 0; m_lockout = 0; m_pending = 0; m_key_ok = 0;
    m_fails = 0; m_idle = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  task automatic model_edge();
    bit grant;
    grant    = m_unlocked && dbg_rd && !dbg_lock;
    m_rvalid = grant;
    m_rdata  = grant ? m_regs[dbg_addr] : 32'd0;
    case (op)
      4'b0001: m_regs[reg_sel] = data_in;
      4'b0010: m_regs[reg_sel] = m_regs[reg_sel] + data_in;
      4'b0100: m_regs[reg_sel] = m_regs[reg_sel] - data_in;
      4'b1000: m_regs[reg_sel] = m_regs[reg_sel] ^ data_in;
      default: ;
    endcase
    if (m_lockout) begin
      // only reset leaves lockout
    end else if (m_pending) begin
      m_pending = 0;
      if (m_key_ok) begin
        m_unlocked = 1; m_fails = 0; m_idle = 0;
      end else begin
        m_fails++;
        if (m_fails == MF) m_lockout = 1;
      end
    end else if (m_unlocked) begin
      if (dbg_lock) m_unlocked = 0;
      else if (dbg_rd) m_idle = 0;
      else if (m_idle + 1 == IT) m_unlocked = 0;
      else m_idle++;
    end else if (dbg_req) begin
      m_pending = 1;
      m_key_ok  = (dbg_key == KEY);
    end
  endtask

  task automatic compare_all();
    check("data_out", data_out, m_regs[reg_sel]);
    check("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, m_rvalid});
    check("dbg_rdata", dbg_rdata, m_rdata);
    check("dbg_unlocked", {31'd0, dbg_unlocked}, {31'd0, m_unlocked});
    check("dbg_lockout", {31'd0, dbg_lockout}, {31'd0, m_lockout});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic quiet();
    op = '0; dbg_req = 0; dbg_lock = 0; dbg_rd = 0; dbg_key = '0;
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic apply_reset();
    quiet();
    rst = 1;
    #2;
    model_reset();
    compare_all();
    rst = 0;
  endtask

  task automatic unlock();
    dbg_req = 1; dbg_key = KEY;
    step();
    dbg_req = 0; dbg_key = '0;
    step();
  endtask

  initial begin
    int cnt;
    model_reset();
    #12;
    compare_all();
    check("reset_rdata", dbg_rdata, 32'd0);
    rst = 0;
    @(posedge clk); #1;

    // Wrapping add on reg1
    op = 4'b0001; reg_sel = 1; data_in = 32'h10; step();
    op = 4'b0010; data_in = 32'hFFFF_FFF5; step();
    op = 4'b0000;
    check("wrap_add", data_out, 32'h5);

    // Read while locked is refused
    dbg_rd = 1; dbg_addr = 1; step(); dbg_rd = 0;
    check("locked_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    check("locked_rdata", dbg_rdata, 32'd0);

    // Unlock and read reg1
    unlock();
    check("unlocked", {31'd0, dbg_unlocked}, 32'd1);
    dbg_rd = 1; dbg_addr = 1; step(); dbg_rd = 0;
    check("read_valid", {31'd0, dbg_rvalid}, 32'd1);
    check("read_data", dbg_rdata, 32'h5);
    step();
    check("rdata_cleared", dbg_rdata, 32'd0);

    // Same-cycle sub and read of reg0 returns the old value
    op = 4'b0100; reg_sel = 0; data_in = 32'd1; dbg_rd = 1; dbg_addr = 0; step();
    op = 4'b0000; dbg_rd = 0; #1;
    check("pre_update_rdata", dbg_rdata, 32'd0);
    check("sub_wrap", data_out, 32'hFFFF_FFFF);

    // Idle relock: count cycles until unlocked drops
    cnt = 0;
    while (dbg_unlocked && cnt < 400) begin step(); cnt++; end
    check("idle_relock_cycles", cnt, IT);

    // Periodic reads keep the port open
    unlock();
    for (int k = 0; k < 5; k++) begin
      repeat (99) step();
      dbg_rd = 1; dbg_addr = 2'(k); step(); dbg_rd = 0;
    end
    check("kept_unlocked", {31'd0, dbg_unlocked}, 32'd1);

    // Voluntary relock wins over a same-cycle read
    dbg_lock = 1; dbg_rd = 1; step(); dbg_lock = 0; dbg_rd = 0;
    check("vol_lock", {31'd0, dbg_unlocked}, 32'd0);
    check("vol_lock_norv", {31'd0, dbg_rvalid}, 32'd0);

    // Three bad keys give lockout; a good key is then ignored
    repeat (MF) begin
      dbg_req = 1; dbg_key = '0; step(); dbg_req = 0; step();
    end
    check("lockout", {31'd0, dbg_lockout}, 32'd1);
    unlock();
    check("lockout_ignores_key", {31'd0, dbg_unlocked}, 32'd0);
    dbg_rd = 1; step(); dbg_rd = 0;
    check("lockout_norv", {31'd0, dbg_rvalid}, 32'd0);
    apply_reset();
    check("reset_clears_lockout", {31'd0, dbg_lockout}, 32'd0);
    step();

    // Reset in the middle of a key check
    dbg_req = 1; dbg_key = KEY; step(); dbg_req = 0;
    apply_reset();
    step();
    check("midcheck_reset", {31'd0, dbg_unlocked}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) begin
        apply_reset();
      end else begin
        op       = ($urandom_range(9) < 7) ? (4'b0001 << $urandom_range(3)) : 4'($urandom);
        data_in  = $urandom;
        reg_sel  = 2'($urandom);
        dbg_req  = ($urandom_range(9) == 0);
        dbg_key  = $urandom_range(1) ? KEY : $urandom;
        dbg_lock = ($urandom_range(49) == 0);
        dbg_rd   = ($urandom_range(9) < 3);
        dbg_addr = 2'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
